sync_fifo: RTL and testbench

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/sync_fifo_if.sv | 28 ++
 rtl/sync_fifo.sv | 92 +++++++++
 tb/tb_sync_fifo.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_if.sv
// Handshake bundle between a FIFO producer/consumer (master) and the FIFO (slave).
interface sync_fifo_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             i_w_en;
  logic [WIDTH-1:0] i_w_data;
  logic             i_r_en;
  logic [WIDTH-1:0] o_r_data;
  logic             o_empty;
  logic             o_full;
  logic             o_almost_full;
  logic [CNT_W-1:0] o_count;
  logic             o_overflow;
  logic             o_underflow;

  modport slave (
    input  i_w_en, i_w_data, i_r_en,
    output o_r_data, o_empty, o_full, o_almost_full, o_count, o_overflow, o_underflow
  );

  modport master (
    output i_w_en, i_w_data, i_r_en,
    input  o_r_data, o_empty, o_full, o_almost_full, o_count, o_overflow, o_underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, registered status flags and
// sticky overflow/underflow indications.
module sync_fifo #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ALMOST_FULL = DEPTH - 2
) (
  input  logic        clk,
  input  logic        i_reset_n,
  sync_fifo_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] r_data_q, r_data_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             afull_q, afull_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             wr_acc, rd_acc;

  // Accept decisions use only registered flags; a read on a full FIFO frees the slot.
  always_comb begin
    wr_acc   = bus.i_w_en & (~full_q | bus.i_r_en);
    rd_acc   = bus.i_r_en & ~empty_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    r_data_d = r_data_q;
    ovf_d    = ovf_q | (bus.i_w_en & full_q & ~bus.i_r_en);
    udf_d    = udf_q | (bus.i_r_en & empty_q & ~bus.i_w_en);

    if (wr_acc) wptr_d = wptr_q + PTR_W'(1);
    if (rd_acc) begin
      rptr_d   = rptr_q + PTR_W'(1);
      r_data_d = mem_q[rptr_q];
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    empty_d = (count_d == CNT_W'(0));
    full_d  = (count_d == CNT_W'(DEPTH));
    afull_d = (count_d >= CNT_W'(ALMOST_FULL));
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      r_data_q <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      r_data_q <= r_data_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is not reset; stale words become unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wptr_q] <= bus.i_w_data;
  end

  assign bus.o_r_data      = r_data_q;
  assign bus.o_empty       = empty_q;
  assign bus.o_full        = full_q;
  assign bus.o_almost_full = afull_q;
  assign bus.o_count       = count_q;
  assign bus.o_overflow    = ovf_q;
  assign bus.o_underflow   = udf_q;
endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: directed scenarios plus random traffic against a queue model.
module tb_sync_fifo;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AF    = DEPTH - 2;

  logic clk;
  logic i_reset_n;
  int   total = 0;
  int   bad   = 0;
  string phase = "init";

  logic [WIDTH-1:0] mq [$];
  logic [WIDTH-1:0] m_rdata;
  bit               m_ovf, m_udf;

  sync_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ALMOST_FULL(AF)) dut (
    .clk      (clk),
    .i_reset_n(i_reset_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("r_data", 32'(bus.o_r_data),      32'(m_rdata));
    chk("count",  32'(bus.o_count),       32'(mq.size()));
    chk("empty",  32'(bus.o_empty),       32'(mq.size() == 0));
    chk("full",   32'(bus.o_full),        32'(mq.size() == DEPTH));
    chk("afull",  32'(bus.o_almost_full), 32'(mq.size() >= AF));
    chk("ovf",    32'(bus.o_overflow),    32'(m_ovf));
    chk("udf",    32'(bus.o_underflow),   32'(m_udf));
  endtask

  task automatic model_update(input bit w, input logic [WIDTH-1:0] d, input bit r);
    bit was_full, was_empty;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    if (w && was_full && !r) m_ovf = 1'b1;
    if (r && was_empty && !w) m_udf = 1'b1;
    if (r && !was_empty) m_rdata = mq.pop_front();
    if (w && (!was_full || r)) mq.push_back(d);
  endtask

  task automatic step(input bit w, input logic [WIDTH-1:0] d, input bit r);
    @(negedge clk);
    bus.i_w_en   = w;
    bus.i_w_data = d;
    bus.i_r_en   = r;
    @(posedge clk);
    model_update(w, d, r);
    #1;
    check_all();
  endtask

  // Asserts reset away from any clock edge and checks outputs before the next edge.
  task automatic do_reset();
    i_reset_n = 1'b0;
    #1;
    mq.delete();
    m_rdata = '0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    check_all();
    @(negedge clk);
    bus.i_w_en = 1'b0;
    bus.i_r_en = 1'b0;
    i_reset_n  = 1'b1;
  endtask

  initial begin
    int writes;
    bit w, r;
    logic [WIDTH-1:0] d;
    i_reset_n    = 1'b1;
    bus.i_w_en   = 1'b0;
    bus.i_w_data = '0;
    bus.i_r_en   = 1'b0;
    mq.delete();
    m_rdata = '0; m_ovf = 1'b0; m_udf = 1'b0;
    #2;
    phase = "reset";
    do_reset();

    phase = "basic";
    step(1, 8'h11, 0);
    step(1, 8'h22, 0);
    step(1, 8'h33, 0);
    step(0, 8'h00, 1); chk("rd0", 32'(bus.o_r_data), 32'h11);
    step(0, 8'h00, 1); chk("rd1", 32'(bus.o_r_data), 32'h22);
    step(0, 8'h00, 1); chk("rd2", 32'(bus.o_r_data), 32'h33);
    chk("empty3", 32'(bus.o_empty), 32'h1);

    phase = "fill";
    for (int i = 0; i < 16; i++) begin
      step(1, WIDTH'(i), 0);
      if (i == 12) chk("af13", 32'(bus.o_almost_full), 32'h0);
      if (i == 13) chk("af14", 32'(bus.o_almost_full), 32'h1);
    end
    chk("full16", 32'(bus.o_full), 32'h1);
    step(1, 8'hFF, 0);
    chk("ovf17", 32'(bus.o_overflow), 32'h1);
    chk("cnt17", 32'(bus.o_count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      step(0, 8'h00, 1);
      chk("drain", 32'(bus.o_r_data), 32'(i));
    end

    phase = "full_rw";
    do_reset();
    for (int i = 0; i < 16; i++) step(1, WIDTH'(i), 0);
    step(1, 8'hA5, 1);
    chk("rd_old", 32'(bus.o_r_data), 32'h00);
    chk("cnt",    32'(bus.o_count), 32'd16);
    chk("noovf",  32'(bus.o_overflow), 32'h0);
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1);
    chk("a5_last", 32'(bus.o_r_data), 32'hA5);

    phase = "empty_rw";
    step(1, 8'h5A, 1);
    chk("cnt1",   32'(bus.o_count), 32'd1);
    chk("hold",   32'(bus.o_r_data), 32'hA5);
    chk("noudf",  32'(bus.o_underflow), 32'h0);
    step(0, 8'h00, 1);
    chk("rd5a", 32'(bus.o_r_data), 32'h5A);

    phase = "wrap";
    do_reset();
    writes = 0;
    while (writes < 40 || mq.size() != 0) begin
      if (writes >= 40)            begin w = 0; r = 1; end
      else if (mq.size() == 0)     begin w = 1; r = 0; end
      else if (mq.size() >= 15)    begin w = 0; r = 1; end
      else                         begin w = 1'($urandom_range(0, 1)); r = 1'($urandom_range(0, 1)); end
      d = WIDTH'($urandom);
      if (w) writes++;
      step(w, d, r);
    end
    chk("wrap_ovf", 32'(bus.o_overflow), 32'h0);
    chk("wrap_udf", 32'(bus.o_underflow), 32'h0);

    phase = "midreset";
    do_reset();
    for (int i = 0; i < 5; i++) step(1, WIDTH'(8'h40 + i), 0);
    do_reset();
    chk("rst_cnt", 32'(bus.o_count), 32'd0);
    step(0, 8'h00, 1);
    chk("rst_udf", 32'(bus.o_underflow), 32'h1);

    phase = "random";
    do_reset();
    for (int i = 0; i < 400; i++) begin
      w = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 9) < ((i / 100) % 2 == 0 ? 3 : 7)) ? 1'b1 : 1'b0;
      step(w, WIDTH'($urandom), r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
